systolic_tile_ctrl: RTL and testbench
=====================================

# systolic_tile_ctrl

Runtime-configured tile sequencer for an N1×N2 output-stationary systolic matmul array. It computes C = A·B with C sized (M1dN1·N1)×(M3dN2·N2) and inner dimension M2. It generates skewed operand read addresses for the A and B buffers and diagonal-skewed per-PE `init` pulses. It sits between the command/CSR front end (`start`/`done` handshake) and the operand memories, which can back-pressure it through `stall`.

## Interface
- `N1`, default 4: PE array rows.
- `N2`, default 4: PE array columns.
- `MATRIXSIZE_W`, default 16: width of every dimension, counter and tile index.
- `ADDR_W_A`, default 12: A buffer address width.
- `ADDR_W_B`, default 12: B buffer address width.

Ports, clock and reset first:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: job request; sampled only while `busy`=0.
- `cfg_m2` in MATRIXSIZE_W: inner dimension M2.
- `cfg_m1dn1` in MATRIXSIZE_W: row tile count.
- `cfg_m3dn2` in MATRIXSIZE_W: column tile count.
- `cfg_base_a` in ADDR_W_A: A buffer base address.
- `cfg_base_b` in ADDR_W_B: B buffer base address (B stored transposed, one M2-row per column tile).
- `stall` in 1: global hold from operand memories; ignored in IDLE.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle job-complete pulse.
- `rd_en` out 1: operand read valid.
- `rd_addr_A` out ADDR_W_A: A read address.
- `rd_addr_B` out ADDR_W_B: B read address.
- `init` out N1*N2: per-PE accumulator-init/result-emit pulse; bit i*N2+j belongs to PE(i,j).
- `tile_r`, `tile_c` out MATRIXSIZE_W: indices of the tile currently issuing.
- `perf_cycles`, `perf_stalls` out 32: performance counters; see Configuration.

## Operation
- FSM states:
  - IDLE → RUN when `start`=1 and all three dims are nonzero. On that transition all `cfg_*` are latched; later changes to `cfg_*` are ignored.
  - RUN → DRAIN after the last issue.
  - DRAIN → IDLE when the skew pipe is empty; `done` pulses on this transition.
- Zero-dimension start: `done` pulses the next cycle. No `rd_en` and no `init` are produced, and `busy` stays 0.
- `start` while `busy`=1 is ignored.
- Loop order in RUN: k (0..M2-1) innermost, then c (0..M3dN2-1), then r (0..M1dN1-1). One issue per non-stalled cycle.
  - `rd_addr_A` = base_a + r·M2 + k.
  - `rd_addr_B` = base_b + c·M2 + k.
- Arithmetic: row bases are maintained incrementally (add M2 on advance). All sums wrap modulo 2^ADDR_W; no saturation and no error.
- Marker shift register m[0..N1+N2-1]:
  - m[0]=1 on the issue with k=0 (tile start).
  - m[0]=1 once more on the first DRAIN advance (flush marker that emits the final tile).
  - `init`[i*N2+j] = m[1+i+j].
- `stall`=1 in RUN or DRAIN freezes counters, addresses, `rd_en`, m[] and FSM. Outputs hold their values.
- Reset mid-job: immediate return to IDLE; the job is abandoned with no `done`.

## Timing
- Reset values: `busy`, `done`, `rd_en`, `init`, `rd_addr_*`, `tile_*` and `perf_*` are all 0.
- All outputs are registered.
- `start` sampled in cycle 0 → `busy`=1 and first `rd_en` in cycle 1. Issues continue on consecutive cycles with no bubbles at tile or row wrap.
- Without stalls, with T = M1dN1·M3dN2·M2:
  - `rd_en` is high in cycles 1..T.
  - Flush marker enters m[0] in cycle T+1.
  - Last `init` (PE(N1-1,N2-1)) fires in cycle T+N1+N2.
  - `done`=1 and `busy`=0 in cycle T+N1+N2+1.
- PE(i,j) `init` lags its tile's k=0 issue by 1+i+j cycles.
- Each stall cycle during RUN or DRAIN delays every later event by exactly one cycle.
- A `start` sampled in the `done` cycle is accepted (back-to-back jobs).

## Configuration
- `SYSTOLIC_CTRL_PERF_EN` defined:
  - `perf_cycles` counts cycles with `busy`=1.
  - `perf_stalls` counts cycles with `busy`=1 and `stall`=1.
  - Both clear on an accepted `start`, hold after `done`, and saturate at 2^32-1.
- Undefined: both ports are constant 0 and no counter logic is synthesised.

## Test plan
- N1=N2=2, M2=4, M1dN1=M3dN2=1, bases 0x010/0x020, start in cycle 0:
  - `rd_en` in cycles 1–4.
  - A addresses 0x010..0x013, B addresses 0x020..0x023.
  - `init`[0] in cycles 2 and 6; `init`[3] in cycles 4 and 8.
  - `done` in cycle 9.
- N1=N2=2, M2=3, M1dN1=2, M3dN2=2:
  - Issue order is (r,c) = (0,0),(0,1),(1,0),(1,1), each tile k=0..2.
  - Tile (1,1) A addresses start at base_a+3 and B addresses start at base_b+3.
  - `done` in cycle 17.
- Same as the first case with `stall` high in cycles 2–3 and again in cycle 7:
  - Addresses and `init` hold while stalled.
  - `done` in cycle 12.
  - With `SYSTOLIC_CTRL_PERF_EN`: `perf_stalls`=3 and `perf_cycles`=11.
- `cfg_m2`=0 with `start`:
  - `done` in cycle 1; `rd_en`, `init` and `busy` stay 0.
- `rst_n` low during RUN in cycle 3 with M2=8:
  - All outputs 0 asynchronously; no `done`.
  - A new `start` after reset runs from k=0.
- `base_a`=0xFFE, M2=4, ADDR_W_A=12:
  - A addresses 0xFFE, 0xFFF, 0x000, 0x001.

Source files
------------

// File: rtl/systolic_tile_ctrl.sv
// Tile sequencer for an N1xN2 output-stationary systolic array: skewed A/B read addresses and per-PE init pulses.
// Optional performance counters are built when SYSTOLIC_CTRL_PERF_EN is defined.
module systolic_tile_ctrl #(
  parameter int N1           = 4,
  parameter int N2           = 4,
  parameter int MATRIXSIZE_W = 16,
  parameter int ADDR_W_A     = 12,
  parameter int ADDR_W_B     = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [MATRIXSIZE_W-1:0] cfg_m2,
  input  logic [MATRIXSIZE_W-1:0] cfg_m1dn1,
  input  logic [MATRIXSIZE_W-1:0] cfg_m3dn2,
  input  logic [ADDR_W_A-1:0]     cfg_base_a,
  input  logic [ADDR_W_B-1:0]     cfg_base_b,
  input  logic                    stall,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [ADDR_W_A-1:0]     rd_addr_A,
  output logic [ADDR_W_B-1:0]     rd_addr_B,
  output logic [N1*N2-1:0]        init,
  output logic [MATRIXSIZE_W-1:0] tile_r,
  output logic [MATRIXSIZE_W-1:0] tile_c,
  output logic [31:0]             perf_cycles,
  output logic [31:0]             perf_stalls
);
  localparam int MK = N1 + N2;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]              state_q, state_d;
  logic                    busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic [MATRIXSIZE_W-1:0] m2_q, m2_d, m1_q, m1_d, m3_q, m3_d;
  logic [MATRIXSIZE_W-1:0] k_q, k_d, c_q, c_d, r_q, r_d;
  logic [ADDR_W_A-1:0]     addr_a_q, addr_a_d, row_a_q, row_a_d;
  logic [ADDR_W_B-1:0]     addr_b_q, addr_b_d, base_b_q, base_b_d;
  logic [MK-1:0]           mark_q, mark_d;
  logic                    dims_ok, k_last, c_last, r_last;

  assign dims_ok = (cfg_m2 != '0) && (cfg_m1dn1 != '0) && (cfg_m3dn2 != '0);
  assign k_last  = (k_q == m2_q - MATRIXSIZE_W'(1));
  assign c_last  = (c_q == m3_q - MATRIXSIZE_W'(1));
  assign r_last  = (r_q == m1_q - MATRIXSIZE_W'(1));

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rd_en_d  = rd_en_q;
    m2_d     = m2_q;
    m1_d     = m1_q;
    m3_d     = m3_q;
    k_d      = k_q;
    c_d      = c_q;
    r_d      = r_q;
    addr_a_d = addr_a_q;
    row_a_d  = row_a_q;
    addr_b_d = addr_b_q;
    base_b_d = base_b_q;
    mark_d   = mark_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (dims_ok) begin
            state_d  = S_RUN;
            busy_d   = 1'b1;
            rd_en_d  = 1'b1;
            m2_d     = cfg_m2;
            m1_d     = cfg_m1dn1;
            m3_d     = cfg_m3dn2;
            k_d      = '0;
            c_d      = '0;
            r_d      = '0;
            addr_a_d = cfg_base_a;
            row_a_d  = cfg_base_a;
            addr_b_d = cfg_base_b;
            base_b_d = cfg_base_b;
            mark_d   = {mark_q[MK-2:0], 1'b1};
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!stall) begin
          mark_d = {mark_q[MK-2:0], 1'b0};
          if (!k_last) begin
            k_d      = k_q + MATRIXSIZE_W'(1);
            addr_a_d = addr_a_q + ADDR_W_A'(1);
            addr_b_d = addr_b_q + ADDR_W_B'(1);
          end else begin
            // Tile boundary: next issue starts a tile, or the flush marker enters on the last one.
            k_d       = '0;
            mark_d[0] = 1'b1;
            if (!c_last) begin
              c_d      = c_q + MATRIXSIZE_W'(1);
              addr_a_d = row_a_q;
              addr_b_d = addr_b_q + ADDR_W_B'(1);
            end else if (!r_last) begin
              c_d      = '0;
              r_d      = r_q + MATRIXSIZE_W'(1);
              addr_a_d = addr_a_q + ADDR_W_A'(1);
              row_a_d  = addr_a_q + ADDR_W_A'(1);
              addr_b_d = base_b_q;
            end else begin
              state_d = S_DRAIN;
              rd_en_d = 1'b0;
            end
          end
        end
      end
      S_DRAIN: begin
        if (!stall) begin
          mark_d = {mark_q[MK-2:0], 1'b0};
          // Only the flush marker at the far PE remains.
          if (mark_q[MK-2:0] == '0) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        rd_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      m2_q     <= '0;
      m1_q     <= '0;
      m3_q     <= '0;
      k_q      <= '0;
      c_q      <= '0;
      r_q      <= '0;
      addr_a_q <= '0;
      row_a_q  <= '0;
      addr_b_q <= '0;
      base_b_q <= '0;
      mark_q   <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      m2_q     <= m2_d;
      m1_q     <= m1_d;
      m3_q     <= m3_d;
      k_q      <= k_d;
      c_q      <= c_d;
      r_q      <= r_d;
      addr_a_q <= addr_a_d;
      row_a_q  <= row_a_d;
      addr_b_q <= addr_b_d;
      base_b_q <= base_b_d;
      mark_q   <= mark_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_A = addr_a_q;
  assign rd_addr_B = addr_b_q;
  assign tile_r    = r_q;
  assign tile_c    = c_q;

  for (genvar i = 0; i < N1; i++) begin : g_row
    for (genvar j = 0; j < N2; j++) begin : g_col
      assign init[i*N2+j] = mark_q[1+i+j];
    end
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] pcyc_q, pstl_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcyc_q <= '0;
      pstl_q <= '0;
    end else if (state_q == S_IDLE && start && dims_ok) begin
      pcyc_q <= '0;
      pstl_q <= '0;
    end else if (busy_q) begin
      if (pcyc_q != '1) pcyc_q <= pcyc_q + 32'd1;
      if (stall && pstl_q != '1) pstl_q <= pstl_q + 32'd1;
    end
  end
  assign perf_cycles = pcyc_q;
  assign perf_stalls = pstl_q;
`else
  assign perf_cycles = '0;
  assign perf_stalls = '0;
`endif
endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Scoreboard bench for systolic_tile_ctrl: per-advance expected steps from a loop-level model, checked by a monitor.
module tb_systolic_tile_ctrl;
  localparam int N1 = 2;
  localparam int N2 = 2;
  localparam int MW = 16;
  localparam int AW = 12;
  localparam int NP = N1 * N2;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0;
  logic [MW-1:0] cfg_m2 = '0, cfg_m1dn1 = '0, cfg_m3dn2 = '0;
  logic [AW-1:0] cfg_base_a = '0, cfg_base_b = '0;
  logic          busy, done, rd_en;
  logic [AW-1:0] rd_addr_A, rd_addr_B;
  logic [NP-1:0] init;
  logic [MW-1:0] tile_r, tile_c;
  logic [31:0]   perf_cycles, perf_stalls;

  systolic_tile_ctrl #(.N1(N1), .N2(N2), .MATRIXSIZE_W(MW), .ADDR_W_A(AW), .ADDR_W_B(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_m2(cfg_m2), .cfg_m1dn1(cfg_m1dn1),
    .cfg_m3dn2(cfg_m3dn2), .cfg_base_a(cfg_base_a), .cfg_base_b(cfg_base_b), .stall(stall),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr_A(rd_addr_A), .rd_addr_B(rd_addr_B),
    .init(init), .tile_r(tile_r), .tile_c(tile_c), .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rd_en;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    int            r;
    int            c;
    logic [NP-1:0] init;
  } step_t;

  step_t exp_q[$];
  int    len_q[$];
  int    first_q[$];
  int    zd_q[$];
  int    cyc = 0, checks = 0, failures = 0;
  bit    active = 0, done_pending = 0, mzd;
  int    remain = 0, busy_cnt = 0, stall_cnt = 0, dut_done_cyc = -1;
  step_t me;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Expected output at each advance step t=1..T+N1+N2, straight from the loop nest and marker rules.
  function automatic void build(input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                                input int m2, input int m1, input int m3);
    int T, L, n, s;
    step_t e;
    T = m1 * m2 * m3;
    L = T + N1 + N2;
    for (int t = 1; t <= L; t++) begin
      n = t - 1;
      e.rd_en = (t <= T);
      e.r = n / (m2 * m3);
      e.c = (n / m2) % m3;
      e.a = AW'(int'(ba) + e.r * m2 + n % m2);
      e.b = AW'(int'(bb) + e.c * m2 + n % m2);
      e.init = '0;
      for (int i = 0; i < N1; i++)
        for (int j = 0; j < N2; j++) begin
          s = t - 1 - i - j;
          if (s >= 1 && ((s <= T && (s - 1) % m2 == 0) || s == T + 1)) e.init[i*N2+j] = 1'b1;
        end
      exp_q.push_back(e);
    end
    len_q.push_back(L);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) dut_done_cyc = cyc;
      if (done_pending) begin
        chk("done", {31'd0, done}, 1);
        chk("busy_at_done", {31'd0, busy}, 0);
        chk("rd_en_at_done", {31'd0, rd_en}, 0);
        chk("init_at_done", {28'd0, init}, 0);
`ifdef SYSTOLIC_CTRL_PERF_EN
        chk("perf_cycles", perf_cycles, busy_cnt);
        chk("perf_stalls", perf_stalls, stall_cnt);
`else
        chk("perf_cycles", perf_cycles, 0);
        chk("perf_stalls", perf_stalls, 0);
`endif
        done_pending = 0;
      end else begin
        if (!active && first_q.size() > 0 && cyc >= first_q[0]) begin
          active = 1;
          void'(first_q.pop_front());
          remain = len_q.pop_front();
          busy_cnt = 0;
          stall_cnt = 0;
        end
        if (active) begin
          if (exp_q.size() == 0) begin
            chk("exp_underflow", 1, 0);
            active = 0;
          end else begin
            me = exp_q[0];
            chk("busy", {31'd0, busy}, 1);
            chk("done_early", {31'd0, done}, 0);
            chk("rd_en", {31'd0, rd_en}, {31'd0, me.rd_en});
            chk("init", {28'd0, init}, {28'd0, me.init});
            if (me.rd_en) begin
              chk("rd_addr_A", {20'd0, rd_addr_A}, {20'd0, me.a});
              chk("rd_addr_B", {20'd0, rd_addr_B}, {20'd0, me.b});
              chk("tile_r", {16'd0, tile_r}, me.r);
              chk("tile_c", {16'd0, tile_c}, me.c);
            end
            busy_cnt++;
            if (stall) stall_cnt++;
            if (!stall) begin
              void'(exp_q.pop_front());
              remain--;
              if (remain == 0) begin
                active = 0;
                done_pending = 1;
              end
            end
          end
        end else begin
          mzd = (zd_q.size() > 0 && zd_q[0] == cyc);
          if (mzd) void'(zd_q.pop_front());
          chk("idle_done", {31'd0, done}, {31'd0, mzd});
          chk("idle_busy", {31'd0, busy}, 0);
          chk("idle_rd_en", {31'd0, rd_en}, 0);
          chk("idle_init", {28'd0, init}, 0);
        end
      end
    end
  end

  task automatic clear_sb();
    exp_q.delete();
    len_q.delete();
    first_q.delete();
    zd_q.delete();
    active = 0;
    done_pending = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_rd_en"}, {31'd0, rd_en}, 0);
    chk({tag, "_init"}, {28'd0, init}, 0);
    chk({tag, "_addr"}, {8'd0, rd_addr_A, rd_addr_B}, 0);
    chk({tag, "_tile"}, {tile_r, tile_c}, 0);
    chk({tag, "_perf"}, perf_cycles | perf_stalls, 0);
  endtask

  // mode 0: no stall; 1: stall in relative cycles 2,3,7; 2: random stall and ignored starts.
  task automatic run_job(input logic [AW-1:0] ba, input logic [AW-1:0] bb, input int m2,
                         input int m1, input int m3, input int mode, input int exp_done, input bit b2b);
    int c0, n;
    cfg_base_a = ba; cfg_base_b = bb;
    cfg_m2 = MW'(m2); cfg_m1dn1 = MW'(m1); cfg_m3dn2 = MW'(m3);
    start = 1'b1;
    stall = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    c0 = cyc;
    build(ba, bb, m2, m1, m3);
    first_q.push_back(c0 + 1);
    @(posedge clk); #1;
    start = 1'b0;
    cfg_base_a = AW'($urandom); cfg_base_b = AW'($urandom);
    cfg_m2 = MW'($urandom_range(0, 9)); cfg_m1dn1 = MW'($urandom_range(0, 9)); cfg_m3dn2 = MW'($urandom_range(0, 9));
    n = 0;
    while (!done_pending && n < 1000) begin
      case (mode)
        1:       stall = ((cyc - c0) == 2) || ((cyc - c0) == 3) || ((cyc - c0) == 7);
        2:       stall = ($urandom_range(0, 3) == 0);
        default: stall = 1'b0;
      endcase
      start = (mode == 2 && busy) ? ($urandom_range(0, 2) == 0) : 1'b0;
      @(posedge clk); #1;
      n++;
    end
    stall = 1'b0;
    start = 1'b0;
    if (!done_pending) begin
      chk("job_timeout", 1, 0);
      clear_sb();
    end
    if (!b2b) begin
      @(posedge clk); #1;
      if (exp_done >= 0) chk("done_cycle", dut_done_cyc - c0, exp_done);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(12'h010, 12'h020, 4, 1, 1, 0, 9, 0);
    run_job(12'h100, 12'h200, 3, 2, 2, 0, 17, 0);
    run_job(12'h010, 12'h020, 4, 1, 1, 1, 12, 0);

    // Zero inner dimension: done only.
    cfg_m2 = '0; cfg_m1dn1 = 16'd1; cfg_m3dn2 = 16'd1;
    start = 1'b1;
    zd_q.push_back(cyc + 1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    // Reset in the middle of a long row.
    cfg_base_a = 12'h300; cfg_base_b = 12'h400; cfg_m2 = 16'd8; cfg_m1dn1 = 16'd1; cfg_m3dn2 = 16'd1;
    start = 1'b1;
    build(12'h300, 12'h400, 8, 1, 1);
    first_q.push_back(cyc + 1);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    clear_sb();
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(12'h040, 12'h080, 8, 1, 1, 0, 13, 0);

    run_job(12'hFFE, 12'h7FF, 4, 1, 1, 0, 9, 0);
    run_job(12'hFFD, 12'hFFC, 3, 2, 2, 0, 17, 1);
    run_job(12'h000, 12'h555, 2, 3, 1, 0, -1, 1);
    run_job(12'h123, 12'h456, 1, 2, 3, 0, -1, 0);

    for (int t = 0; t < 14; t++)
      run_job(AW'($urandom), AW'($urandom), $urandom_range(1, 5), $urandom_range(1, 3),
              $urandom_range(1, 3), 2, -1, (t != 13) && ($urandom_range(0, 1) == 1));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
